// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue front end: opcode map, FSM encoding and
// the opcode legality check.
package alu_pkg;
  localparam int OPC_W       = 5;
  localparam int DATA_W      = 32;
  localparam int ALU_LAT_DEF = 2;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OPC_W-1:0] OP_ADDC = 5'd1;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd2;
  localparam logic [OPC_W-1:0] OP_SUBB = 5'd3;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd4;
  localparam logic [OPC_W-1:0] OP_FADD = 5'd5;
  localparam logic [OPC_W-1:0] OP_FSUB = 5'd6;
  localparam logic [OPC_W-1:0] OP_FMUL = 5'd7;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd8;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd9;
  localparam logic [OPC_W-1:0] OP_XOR  = 5'd10;
  localparam logic [OPC_W-1:0] OP_NAND = 5'd11;
  localparam logic [OPC_W-1:0] OP_NOR  = 5'd12;
  localparam logic [OPC_W-1:0] OP_XNOR = 5'd13;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd14;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'd15;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;

  function automatic logic op_legal(input logic [OPC_W-1:0] op, input int num_ops);
    return int'(op) < num_ops;
  endfunction
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-drive and response signals of the issue controller.
interface alu_issue_ctrl_if
  import alu_pkg::*;
#(
  parameter int TAG_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [OPC_W-1:0]  req_opcode;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;
  logic [OPC_W-1:0]  alu_opcode;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic              alu_enable;
  logic [DATA_W-1:0] alu_out;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, req_tag, alu_out, rsp_ready,
    output req_ready, alu_opcode, alu_a, alu_b, alu_enable,
    output rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport master (
    output req_valid, req_opcode, req_a, req_b, req_tag, alu_out, rsp_ready,
    input  req_ready, alu_opcode, alu_a, alu_b, alu_enable,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/alu_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit to tell full from empty.
module alu_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 73
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  // A pop in the same cycle never frees room for a push while full.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
  assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Buffers tagged ALU requests, issues them one at a time to the non-pipelined ALU,
// waits its fixed latency and returns the captured result with the tag.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = ALU_LAT_DEF,
  parameter int NUM_OPS = 16,
  parameter int TAG_W   = 4
) (
  input logic              clk,
  input logic              rst,
  alu_issue_ctrl_if.slave  bus
);
  localparam int FW    = OPC_W + 2 * DATA_W + TAG_W;
  localparam int CNT_W = $clog2(ALU_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]     op_q, op_d, head;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              pop, take, full, empty, busy, in_resp;

  alu_req_fifo #(.DEPTH(DEPTH), .W(FW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.req_valid),
    .wdata_i ({bus.req_opcode, bus.req_a, bus.req_b, bus.req_tag}),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign bus.req_ready = !full;

  // A completing response hands over straight to the next queued op, so the
  // IDLE decision is also taken in RESP on the handshake cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;
    take    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE:  take = 1'b1;
      ST_ISSUE: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          data_d  = bus.alu_out;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
          take    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (take && !empty) begin
      pop  = 1'b1;
      op_d = head;
      if (op_legal(head[FW-1 -: OPC_W], NUM_OPS)) begin
        err_d   = 1'b0;
        state_d = ST_ISSUE;
      end else begin
        err_d   = 1'b1;
        data_d  = '0;
        state_d = ST_RESP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q   <= op_d;
    data_q <= data_d;
    err_q  <= err_d;
  end

  // ALU inputs are forced to zero outside ISSUE/WAIT so the ALU stays quiet.
  assign busy    = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign in_resp = (state_q == ST_RESP);

  assign bus.alu_enable = (state_q == ST_ISSUE);
  assign bus.alu_opcode = busy ? op_q[FW-1 -: OPC_W] : '0;
  assign bus.alu_a      = busy ? op_q[TAG_W + 2*DATA_W - 1 -: DATA_W] : '0;
  assign bus.alu_b      = busy ? op_q[TAG_W + DATA_W - 1 -: DATA_W] : '0;
  assign bus.rsp_valid  = in_resp;
  assign bus.rsp_data   = in_resp ? data_q : '0;
  assign bus.rsp_tag    = in_resp ? op_q[TAG_W-1:0] : '0;
  assign bus.rsp_err    = in_resp && err_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a two-cycle ALU model behind it.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;
  int   en_count;
  int   rsp_n;
  int   en_cyc [64];
  logic [31:0] rsp_data_log [64];
  logic [3:0]  rsp_tag_log [64];
  logic [31:0] alu_r1, alu_r2;
  logic [31:0] exp_d [5];

  alu_issue_ctrl_if #(.TAG_W(4)) bus ();

  alu_issue_ctrl #(.DEPTH(4), .ALU_LAT(2), .NUM_OPS(16), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      default: return 32'h0BAD0BAD;
    endcase
  endfunction

  // ALU model: result valid only in the second cycle after the enable cycle.
  always @(posedge clk) begin
    alu_r1 <= bus.alu_enable ? alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b) : 32'hDEADBEEF;
    alu_r2 <= alu_r1;
  end
  assign bus.alu_out = alu_r2;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.alu_enable) begin
      if (en_count < 64) en_cyc[en_count] <= cyc;
      en_count <= en_count + 1;
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (rsp_n < 64) begin
        rsp_data_log[rsp_n] <= bus.rsp_data;
        rsp_tag_log[rsp_n]  <= bus.rsp_tag;
      end
      rsp_n <= rsp_n + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag);
    bus.req_valid  = 1'b1;
    bus.req_opcode = op;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.req_tag    = tag;
  endtask

  task automatic idle_req();
    bus.req_valid  = 1'b0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
  endtask

  initial begin
    int n;
    int eb;
    int rb;
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    en_count = 0;
    rsp_n = 0;
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    idle_req();
    exp_d[0] = 32'h00000003;
    exp_d[1] = 32'h00000007;
    exp_d[2] = 32'h000000FF;
    exp_d[3] = 32'h00000F0F;
    exp_d[4] = 32'hFFFFFFFF;

    tick();
    chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_alu_enable", 32'(bus.alu_enable), 32'd0);
    chk("reset_alu_a", bus.alu_a, 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single AND
    bus.rsp_ready = 1'b0;
    eb = en_count;
    drive_req(OP_AND, 32'hF0F0F0F0, 32'hFF00FF00, 4'd3);
    tick();
    idle_req();
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("and_latency", 32'(n), 32'd4);
    chk("and_data", bus.rsp_data, 32'hF000F000);
    chk("and_tag", 32'(bus.rsp_tag), 32'd3);
    chk("and_err", 32'(bus.rsp_err), 32'd0);
    chk("and_enable_pulses", 32'(en_count - eb), 32'd1);
    chk("and_alu_opcode_resp", 32'(bus.alu_opcode), 32'd0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("and_rsp_done", 32'(bus.rsp_valid), 32'd0);

    // Illegal opcode
    eb = en_count;
    drive_req(5'd20, 32'h11111111, 32'h22222222, 4'd7);
    tick();
    idle_req();
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("ill_latency", 32'(n), 32'd1);
    chk("ill_data", bus.rsp_data, 32'd0);
    chk("ill_err", 32'(bus.rsp_err), 32'd1);
    chk("ill_tag", 32'(bus.rsp_tag), 32'd7);
    tick();
    chk("ill_no_enable", 32'(en_count - eb), 32'd0);

    // Back-to-back XOR then NOR
    tick();
    eb = en_count;
    rb = rsp_n;
    drive_req(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 4'd1);
    tick();
    drive_req(OP_NOR, 32'h00000000, 32'h00000000, 4'd2);
    tick();
    idle_req();
    n = 0;
    while (rsp_n - rb < 2 && n < 30) begin
      tick();
      n++;
    end
    chk("b2b_count", 32'(rsp_n - rb), 32'd2);
    chk("b2b_xor_data", rsp_data_log[rb], 32'hF0F00F0F);
    chk("b2b_xor_tag", 32'(rsp_tag_log[rb]), 32'd1);
    chk("b2b_nor_data", rsp_data_log[rb+1], 32'hFFFFFFFF);
    chk("b2b_nor_tag", 32'(rsp_tag_log[rb+1]), 32'd2);
    chk("b2b_enable_gap", 32'(en_cyc[eb+1] - en_cyc[eb]), 32'd4);

    // Fill with rsp_ready low, with operand hold during WAIT
    tick();
    bus.rsp_ready = 1'b0;
    chk("fill_ready0", 32'(bus.req_ready), 32'd1);
    drive_req(OP_ADD, 32'd1, 32'd2, 4'd0);
    tick();
    chk("fill_ready1", 32'(bus.req_ready), 32'd1);
    drive_req(OP_SUB, 32'd10, 32'd3, 4'd1);
    tick();
    chk("hold_issue_en", 32'(bus.alu_enable), 32'd1);
    chk("hold_issue_a", bus.alu_a, 32'd1);
    chk("hold_issue_b", bus.alu_b, 32'd2);
    chk("fill_ready2", 32'(bus.req_ready), 32'd1);
    drive_req(OP_OR, 32'h000000F0, 32'h0000000F, 4'd2);
    tick();
    chk("hold_wait1_en", 32'(bus.alu_enable), 32'd0);
    chk("hold_wait1_a", bus.alu_a, 32'd1);
    chk("hold_wait1_b", bus.alu_b, 32'd2);
    chk("fill_ready3", 32'(bus.req_ready), 32'd1);
    drive_req(OP_AND, 32'h0000FFFF, 32'h00000F0F, 4'd3);
    tick();
    chk("hold_wait2_a", bus.alu_a, 32'd1);
    chk("hold_wait2_b", bus.alu_b, 32'd2);
    chk("fill_ready4", 32'(bus.req_ready), 32'd1);
    drive_req(OP_XNOR, 32'h00000000, 32'h00000000, 4'd4);
    tick();
    idle_req();
    chk("fill_full", 32'(bus.req_ready), 32'd0);
    chk("fill_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("fill_rsp_tag0", 32'(bus.rsp_tag), 32'd0);
    chk("fill_rsp_data0", bus.rsp_data, 32'd3);
    chk("fill_alu_a_resp", bus.alu_a, 32'd0);
    tick();
    tick();
    tick();
    chk("stall_valid", 32'(bus.rsp_valid), 32'd1);
    chk("stall_tag", 32'(bus.rsp_tag), 32'd0);
    chk("stall_full", 32'(bus.req_ready), 32'd0);
    rb = rsp_n;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (rsp_n - rb < 5 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_count", 32'(rsp_n - rb), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("drain_tag%0d", i), 32'(rsp_tag_log[rb+i]), 32'(i));
      chk($sformatf("drain_data%0d", i), rsp_data_log[rb+i], exp_d[i]);
    end

    // Reset during WAIT
    tick();
    drive_req(OP_AND, 32'h12345678, 32'hFFFFFFFF, 4'd5);
    tick();
    drive_req(OP_OR, 32'h0000000F, 32'h000000F0, 4'd6);
    tick();
    idle_req();
    tick();
    chk("rst_pre_wait_a", bus.alu_a, 32'h12345678);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu_enable", 32'(bus.alu_enable), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    tick();
    rst = 1'b0;
    eb = en_count;
    rb = rsp_n;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_no_response", 32'(rsp_n - rb), 32'd0);
    chk("rst_no_enable", 32'(en_count - eb), 32'd0);
    chk("rst_ready_after", 32'(bus.req_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Front-end sequencer that drives the non-pipelined 32-bit ALU: accepts tagged operation requests over a valid/ready interface and buffers them in a small FIFO. It issues one operation at a time on the ALU's opcode/a/b/enable inputs, waits the fixed ALU latency, captures the ALU out bus and returns it with the tag over a valid/ready response interface. It sits between the instruction decode stage and the ALU.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
ALU_LAT, 2, clk cycles from the enable cycle to a valid ALU out
NUM_OPS, 16, opcodes 0..NUM_OPS-1 legal; others flagged as error
TAG_W, 4, request/response tag width

Ports:
clk  in  1  clock; all flops rise-edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept
req_opcode  in  5  ALU opcode
req_a  in  32  operand a
req_b  in  32  operand b
req_tag  in  TAG_W  caller tag
alu_opcode  out  5  to ALU opcode
alu_a  out  32  to ALU a
alu_b  out  32  to ALU b
alu_enable  out  1  to ALU enable (decoder enable)
alu_out  in  32  ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_data  out  32  result (0 on error)
rsp_tag  out  TAG_W  echoed tag
rsp_err  out  1  illegal opcode

Behaviour:
- Reset (async, immediate): FIFO emptied, FSM=IDLE, counter=0. req_ready=1 after reset. All other outputs are 0. An in-flight operation is discarded with no response.
- FIFO: push on req_valid&&req_ready. req_ready = !full, registered from pointers. No push while full, even if a pop happens the same cycle. Pointers are DEPTH-wrapping with an extra wrap bit. Pop only in IDLE when !empty.
- FSM states:
  - IDLE: if !empty, pop the head into the op register. If opcode >= NUM_OPS, go to RESP with err=1 and data=0 and no ALU activity. Otherwise go to ISSUE.
  - ISSUE (1 cycle): alu_enable=1; alu_opcode/a/b = op register; cnt=0; go to WAIT.
  - WAIT: alu_enable=0; alu_opcode/a/b held stable; cnt++. When cnt==ALU_LAT-1, capture alu_out into rsp_data on that edge and go to RESP. Net effect: enable in cycle T, alu_out sampled at the end of cycle T+ALU_LAT.
  - RESP: rsp_valid=1; rsp_data/tag/err stable until rsp_valid&&rsp_ready, then go to IDLE.
- alu_opcode/a/b are zero in IDLE and RESP (no ALU toggling while idle).
- Back-to-back requests: minimum 2+ALU_LAT cycles per op: pop/IDLE, ISSUE, WAIT×ALU_LAT, RESP with immediate ready. Issue order equals arrival order; responses are in order.
- Pushes continue during ISSUE/WAIT/RESP. rsp_ready held low stalls the FSM in RESP; the FIFO fills and req_ready deasserts.
- Width rules: no arithmetic on data. cnt width is clog2(ALU_LAT)+1. Tag passes through unmodified.

Decomposition:
- Shared package alu_pkg: opcode constants (OP_ADD=0, OP_ADDC=1, OP_SUB=2, OP_SUBB=3, OP_MUL=4, OP_FADD=5, OP_FSUB=6, OP_FMUL=7, OP_AND=8, OP_OR=9, OP_XOR=10, OP_NAND=11, OP_NOR=12, OP_XNOR=13, OP_NOT=14, OP_NEG=15), FSM state encoding, default ALU_LAT.
- One sub-module: alu_req_fifo (synchronous FIFO, DEPTH×(5+32+32+TAG_W), async active-high rst, full/empty).

Test Plan:
- Single AND: push opcode 8, a=0xF0F0F0F0, b=0xFF00FF00, tag 3; bench ALU model with ALU_LAT=2. Required: alu_enable pulses exactly 1 cycle; rsp_valid 4 cycles after the push; rsp_data=0xF000F000, tag=3, err=0.
- Illegal opcode 20, tag 7: alu_enable never asserts. Required: rsp_valid with data=0, err=1, tag=7.
- Fill: 5 pushes with rsp_ready=0. Required: first is popped; req_ready drops after the 5th push (4 queued). Releasing rsp_ready drains 5 in-order responses with tags 0..4.
- Back-to-back: XOR (10) a=0xFFFF0000 b=0x0F0F0F0F, then NOR (12) a=0 b=0, rsp_ready=1. Required: results 0xF0F00F0F then 0xFFFFFFFF; second enable exactly 4 cycles after the first.
- Reset mid-WAIT: assert rst during WAIT. Required: rsp_valid=0, alu_enable=0, req_ready=1 the same cycle; no response for the discarded op.
- Operand hold: during WAIT, drive new pushes with different a/b. Required: alu_a/alu_b unchanged from the issue cycle until RESP.
